// File: rtl/dmem_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_bus_if
// Bundles the MEM-stage request, the memory bus and the result/stall lines
// that connect to dmem_bus_ctrl.
//   proc2Dmem_*       : request from the MEM stage (command/addr/store data)
//   mem2proc_*        : memory acceptance tag, returning tag and load data
//   proc2mem_*        : command/addr/data driven to memory
//   Dmem2proc_data    : registered load result
//   dmem_stall        : pipeline hold (IF..MEM)
//   dmem_stall_cycles : running count of stalled cycles
// Modports: slave = the controller, master = whoever drives requests/memory.
// The bus command encodings below mirror sys_defs.vh.
// ---------------------------------------------------------------------------
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

interface dmem_bus_if;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2Dmem_data;
  logic [3:0]  mem2proc_response;
  logic [3:0]  mem2proc_tag;
  logic [31:0] mem2proc_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [31:0] proc2mem_data;
  logic [31:0] Dmem2proc_data;
  logic        dmem_stall;
  logic [31:0] dmem_stall_cycles;

  modport slave (
    input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    input  mem2proc_response, mem2proc_tag, mem2proc_data,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output Dmem2proc_data, dmem_stall, dmem_stall_cycles
  );

  modport master (
    output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
    output mem2proc_response, mem2proc_tag, mem2proc_data,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  Dmem2proc_data, dmem_stall, dmem_stall_cycles
  );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_bus_ctrl
// Single-outstanding data-memory bus controller between the MEM stage and a
// tagged memory. Latches one request, retries it until accepted, waits for
// the matching load tag, then releases the pipeline for one DONE cycle.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : dmem_bus_if.slave (request, memory bus, result, stall, stall count)
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | no request outstanding; latch a LOAD/STORE when one appears
// S_ISSUE    | drive latched request to memory until response != 0
// S_WAIT_TAG | load accepted; wait for mem2proc_tag == pending tag
// S_DONE     | one-cycle release of the stall; always back to S_IDLE
// ---------------------------------------------------------------------------
module dmem_bus_ctrl (
  input  logic       clk,
  input  logic       rst,
  dmem_bus_if.slave  bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_WAIT_TAG = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  tag_q, tag_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        req_valid;
  logic [1:0]  state_eff;
  logic        stall;

  always_comb begin
    // 2'h3 is not a real command, so only LOAD/STORE count as requests
    req_valid = (bus.proc2Dmem_command == `BUS_LOAD) ||
                (bus.proc2Dmem_command == `BUS_STORE);
    // Combinational outputs treat a reset cycle as IDLE even before the
    // state flop has been cleared by the edge.
    state_eff = rst ? S_IDLE : state_q;

    state_d = state_q;
    tag_d   = tag_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cmd_d   = bus.proc2Dmem_command;
          addr_d  = bus.proc2Dmem_addr;
          data_d  = bus.proc2Dmem_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.mem2proc_response != 4'd0) begin
          if (cmd_q == `BUS_STORE) begin
            state_d = S_DONE;
          end else begin
            tag_d   = bus.mem2proc_response;
            state_d = S_WAIT_TAG;
          end
        end
      end
      S_WAIT_TAG: begin
        if ((bus.mem2proc_tag != 4'd0) && (bus.mem2proc_tag == tag_q)) begin
          rdata_d = bus.mem2proc_data;
          tag_d   = 4'd0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    stall = ((state_eff == S_IDLE) && req_valid) ||
            (state_eff == S_ISSUE) || (state_eff == S_WAIT_TAG);

    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tag_q       <= 4'd0;
      cmd_q       <= `BUS_NONE;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      rdata_q     <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.proc2mem_command  = (state_eff == S_ISSUE) ? cmd_q : `BUS_NONE;
  assign bus.proc2mem_addr     = addr_q;
  assign bus.proc2mem_data     = data_q;
  assign bus.Dmem2proc_data    = rdata_q;
  assign bus.dmem_stall        = stall;
  assign bus.dmem_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_bus_ctrl
// Self-checking bench for dmem_bus_ctrl. A per-transaction memory responder
// reacts to the bus; expected results are queued when a request is driven
// and compared when the controller releases the stall.
// ---------------------------------------------------------------------------
module tb_dmem_bus_ctrl;

  logic clk;
  logic rst;

  dmem_bus_if bus ();

  dmem_bus_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          len;
  } exp_t;

  exp_t        sb[$];
  int          n_checks;
  int          n_fail;
  logic [31:0] last_rdata;
  logic [31:0] exp_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.proc2Dmem_command = `BUS_NONE;
    bus.proc2Dmem_addr    = 32'd0;
    bus.proc2Dmem_data    = 32'd0;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_tag      = 4'd0;
    bus.mem2proc_data     = 32'd0;
  endtask

  // One full transaction. The command is held through the DONE cycle (as a
  // stalled MEM stage would) while addr/data are scrambled after the first
  // cycle, so any re-latching or re-issue shows up.
  task automatic run_txn(input logic [1:0] cmd, input logic [31:0] addr,
                         input logic [31:0] wdata, input int n_rej,
                         input logic [3:0] resp, input int tag_dly,
                         input logic [31:0] rdata, input logic [3:0] bad_tag,
                         input int bad_dly);
    exp_t e;
    exp_t got_e;
    int   issue_seen;
    int   acc_c;
    int   stall_seen;
    bit   done;
    issue_seen = 0;
    acc_c      = -1;
    stall_seen = 0;
    done       = 1'b0;
    e.rdata = (cmd == `BUS_LOAD) ? rdata : last_rdata;
    e.len   = (cmd == `BUS_LOAD) ? 2 + n_rej + tag_dly : 2 + n_rej;
    sb.push_back(e);
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      bus.proc2Dmem_command = cmd;
      bus.proc2Dmem_addr    = (c == 0) ? addr  : ~addr;
      bus.proc2Dmem_data    = (c == 0) ? wdata : ~wdata;
      bus.mem2proc_response = 4'd0;
      bus.mem2proc_tag      = 4'd0;
      bus.mem2proc_data     = 32'hCAFE_0000 + c;
      if (bus.proc2mem_command != `BUS_NONE) begin
        issue_seen++;
        check_eq("issue_cmd",  {30'd0, bus.proc2mem_command}, {30'd0, cmd});
        check_eq("issue_addr", bus.proc2mem_addr, addr);
        check_eq("issue_data", bus.proc2mem_data, wdata);
        if (issue_seen > n_rej) begin
          bus.mem2proc_response = resp;
          acc_c = c;
        end
      end else if (acc_c >= 0 && cmd == `BUS_LOAD) begin
        if (c == acc_c + tag_dly) begin
          bus.mem2proc_tag  = resp;
          bus.mem2proc_data = rdata;
        end else if (bad_tag != 4'd0 && c == acc_c + bad_dly) begin
          bus.mem2proc_tag  = bad_tag;
          bus.mem2proc_data = 32'h0000_0BAD;
        end
      end
      #1;
      if (c == 0) begin
        check_eq("req_stall", {31'd0, bus.dmem_stall}, 32'd1);
      end
      if (bus.dmem_stall) begin
        stall_seen++;
      end else if (c > 0) begin
        got_e = sb.pop_front();
        check_eq("done_rdata", bus.Dmem2proc_data, got_e.rdata);
        check_eq("stall_len",  stall_seen, got_e.len);
        check_eq("done_cmd",   {30'd0, bus.proc2mem_command}, {30'd0, `BUS_NONE});
        check_eq("issue_cnt",  issue_seen, n_rej + 1);
        exp_cnt = exp_cnt + got_e.len;
        check_eq("stall_cnt",  bus.dmem_stall_cycles, exp_cnt);
        last_rdata = got_e.rdata;
        done = 1'b1;
      end
    end
    if (!done) begin
      check_eq("txn_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    // cycle after DONE: back in IDLE, nothing re-issued
    @(negedge clk);
    drive_idle();
    #1;
    check_eq("post_stall", {31'd0, bus.dmem_stall}, 32'd0);
    check_eq("post_cmd",   {30'd0, bus.proc2mem_command}, {30'd0, `BUS_NONE});
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    last_rdata = 32'd0;
    exp_cnt    = 32'd0;
    rst        = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_cmd",   {30'd0, bus.proc2mem_command}, {30'd0, `BUS_NONE});
    check_eq("rst_addr",  bus.proc2mem_addr, 32'd0);
    check_eq("rst_data",  bus.proc2mem_data, 32'd0);
    check_eq("rst_rdata", bus.Dmem2proc_data, 32'd0);
    check_eq("rst_cnt",   bus.dmem_stall_cycles, 32'd0);
    check_eq("rst_stall", {31'd0, bus.dmem_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // store, accepted first time
    run_txn(`BUS_STORE, 32'h100, 32'hDEAD_BEEF, 0, 4'd3, 0, 32'd0, 4'd0, 0);
    // load, tag returns three cycles after acceptance
    run_txn(`BUS_LOAD, 32'h40, 32'h0, 0, 4'd5, 3, 32'h1234_5678, 4'd0, 0);
    // load rejected four times, then accepted
    run_txn(`BUS_LOAD, 32'h80, 32'h0, 4, 4'd2, 1, 32'hA5A5_0F0F, 4'd0, 0);
    // store must leave the load result alone
    run_txn(`BUS_STORE, 32'h104, 32'h0BAD_F00D, 1, 4'd1, 0, 32'd0, 4'd0, 0);
    // foreign tag arrives before the pending one
    run_txn(`BUS_LOAD, 32'hC0, 32'h0, 0, 4'd7, 3, 32'h0000_0077, 4'd3, 1);

    // reserved command value 2'h3 is not a request
    @(negedge clk);
    bus.proc2Dmem_command = 2'h3;
    #1;
    check_eq("cmd3_stall", {31'd0, bus.dmem_stall}, 32'd0);
    @(negedge clk);
    drive_idle();
    #1;
    check_eq("cmd3_issue", {30'd0, bus.proc2mem_command}, {30'd0, `BUS_NONE});

    // reset while waiting for tag 4
    @(negedge clk);
    bus.proc2Dmem_command = `BUS_LOAD;
    bus.proc2Dmem_addr    = 32'h200;
    @(negedge clk);
    bus.mem2proc_response = 4'd4;
    @(negedge clk);
    bus.mem2proc_response = 4'd0;
    #1;
    check_eq("wait_stall", {31'd0, bus.dmem_stall}, 32'd1);
    check_eq("wait_cmd",   {30'd0, bus.proc2mem_command}, {30'd0, `BUS_NONE});
    @(negedge clk);
    rst = 1'b1;
    bus.proc2Dmem_command = `BUS_NONE;
    #1;
    check_eq("rst_wait_stall", {31'd0, bus.dmem_stall}, 32'd0);
    check_eq("rst_wait_cmd",   {30'd0, bus.proc2mem_command}, {30'd0, `BUS_NONE});
    @(negedge clk);
    bus.proc2Dmem_command = `BUS_LOAD;
    #1;
    check_eq("rst_req_stall", {31'd0, bus.dmem_stall}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.proc2Dmem_command = `BUS_NONE;
    bus.mem2proc_tag      = 4'd4;
    bus.mem2proc_data     = 32'h4444_4444;
    #1;
    check_eq("old_tag_stall", {31'd0, bus.dmem_stall}, 32'd0);
    check_eq("rst_mid_rdata", bus.Dmem2proc_data, 32'd0);
    check_eq("rst_mid_cnt",   bus.dmem_stall_cycles, 32'd0);
    check_eq("rst_mid_addr",  bus.proc2mem_addr, 32'd0);
    @(negedge clk);
    drive_idle();
    #1;
    check_eq("old_tag_rdata", bus.Dmem2proc_data, 32'd0);
    check_eq("old_tag_idle",  {31'd0, bus.dmem_stall}, 32'd0);
    last_rdata = 32'd0;
    exp_cnt    = 32'd0;

    // after reset: highest tag value, with retries
    run_txn(`BUS_LOAD, 32'hFFFF_FFFC, 32'h0, 2, 4'd15, 1, 32'hFEED_FACE, 4'd0, 0);
    run_txn(`BUS_STORE, 32'h0, 32'hFFFF_FFFF, 3, 4'd9, 0, 32'd0, 4'd0, 0);

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
